// File: rtl/game_sequencer_if.sv
// Breakout game-flow signal bundle: collision/button inputs and sequencer outputs.
// The pause wire only exists when PAUSE_EN is defined.
interface game_sequencer_if #(
   parameter int NUM_BLOCKS = 40
);
   localparam int BW = $clog2(NUM_BLOCKS + 1);

   logic          start;
   logic          hit_block;
   logic          hit_lava;
   logic          endgame_block;
`ifdef PAUSE_EN
   logic          pause;
`endif
   logic [2:0]    state;
   logic          score_start;
   logic          ball_hold;
   logic          ball_launch;
   logic          play_en;
   logic [2:0]    lives_left;
   logic [BW-1:0] blocks_left;
   logic          game_over;
   logic          victory;

`ifdef PAUSE_EN
   modport master (
      output start, hit_block, hit_lava, endgame_block, pause,
      input  state, score_start, ball_hold, ball_launch, play_en,
             lives_left, blocks_left, game_over, victory
   );
   modport slave (
      input  start, hit_block, hit_lava, endgame_block, pause,
      output state, score_start, ball_hold, ball_launch, play_en,
             lives_left, blocks_left, game_over, victory
   );
`else
   modport master (
      output start, hit_block, hit_lava, endgame_block,
      input  state, score_start, ball_hold, ball_launch, play_en,
             lives_left, blocks_left, game_over, victory
   );
   modport slave (
      input  start, hit_block, hit_lava, endgame_block,
      output state, score_start, ball_hold, ball_launch, play_en,
             lives_left, blocks_left, game_over, victory
   );
`endif
endinterface

// File: rtl/game_sequencer.sv
// Breakout game-flow FSM: idle -> serve -> play -> lost -> over/win, with lives and block counts.
// Optional pause state is built when the PAUSE_EN macro is defined.
module game_sequencer #(
   parameter int NUM_BLOCKS  = 40,
   parameter int LIVES       = 3,
   parameter int SERVE_DELAY = 50000000,
   parameter int LOST_DELAY  = 25000000
) (
   input  logic             clock_i,
   input  logic             reset_i,
   game_sequencer_if.slave  bus_io
);
   localparam int BW   = $clog2(NUM_BLOCKS + 1);
   localparam int MAXD = (SERVE_DELAY > LOST_DELAY) ? SERVE_DELAY : LOST_DELAY;
   localparam int TW   = ($clog2(MAXD) > 0) ? $clog2(MAXD) : 1;

   localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_DELAY - 1);
   localparam logic [TW-1:0] LOST_LAST  = TW'(LOST_DELAY - 1);
   localparam logic [TW-1:0] T_ONE      = TW'(1);
   localparam logic [BW-1:0] B_ONE      = BW'(1);
   localparam logic [BW-1:0] B_FULL     = BW'(NUM_BLOCKS);
   localparam logic [2:0]    L_FULL     = 3'(LIVES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SERVE  = 3'd1,
      S_PLAY   = 3'd2,
      S_LOST   = 3'd3,
      S_OVER   = 3'd4,
      S_WIN    = 3'd5,
      S_PAUSED = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    lives_q, lives_d;
   logic [BW-1:0] blocks_q, blocks_d;
   logic          start_h_q, block_h_q, lava_h_q;
   logic          score_start_q, score_start_d;
   logic          ball_launch_q, ball_launch_d;
   logic          ball_hold_q, ball_hold_d;
   logic          play_en_q, play_en_d;
   logic          game_over_q, game_over_d;
   logic          victory_q, victory_d;
   logic          start_e, block_e, lava_e;

   assign start_e = bus_io.start & ~start_h_q;
   assign block_e = bus_io.hit_block & ~block_h_q;
   assign lava_e  = bus_io.hit_lava & ~lava_h_q;

`ifdef PAUSE_EN
   logic pause_h_q;
   logic pause_e;
   assign pause_e = bus_io.pause & ~pause_h_q;

   always_ff @(posedge clock_i) begin
      if (!reset_i) pause_h_q <= 1'b0;
      else          pause_h_q <= bus_io.pause;
   end
`endif

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state_q       <= S_IDLE;
         timer_q       <= '0;
         lives_q       <= L_FULL;
         blocks_q      <= B_FULL;
         start_h_q     <= 1'b0;
         block_h_q     <= 1'b0;
         lava_h_q      <= 1'b0;
         score_start_q <= 1'b0;
         ball_launch_q <= 1'b0;
         ball_hold_q   <= 1'b0;
         play_en_q     <= 1'b0;
         game_over_q   <= 1'b0;
         victory_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         lives_q       <= lives_d;
         blocks_q      <= blocks_d;
         start_h_q     <= bus_io.start;
         block_h_q     <= bus_io.hit_block;
         lava_h_q      <= bus_io.hit_lava;
         score_start_q <= score_start_d;
         ball_launch_q <= ball_launch_d;
         ball_hold_q   <= ball_hold_d;
         play_en_q     <= play_en_d;
         game_over_q   <= game_over_d;
         victory_q     <= victory_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      lives_d  = lives_q;
      blocks_d = blocks_q;
      case (state_q)
         S_IDLE: begin
            if (start_e) begin
               state_d  = S_SERVE;
               timer_d  = '0;
               lives_d  = L_FULL;
               blocks_d = B_FULL;
            end
         end
         S_SERVE: begin
            if (timer_q == SERVE_LAST || start_e) begin
               state_d = S_PLAY;
               timer_d = '0;
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         S_PLAY: begin
            // Only the highest-priority event acts; the others are dropped.
            if (bus_io.endgame_block) begin
               state_d = S_OVER;
            end else if (lava_e) begin
               lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
               state_d = (lives_q <= 3'd1) ? S_OVER : S_LOST;
               timer_d = '0;
            end else if (block_e) begin
               blocks_d = (blocks_q != '0) ? blocks_q - B_ONE : '0;
               if (blocks_q <= B_ONE) state_d = S_WIN;
`ifdef PAUSE_EN
            end else if (pause_e) begin
               state_d = S_PAUSED;
`endif
            end
         end
         S_LOST: begin
            if (timer_q == LOST_LAST) begin
               state_d = S_SERVE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + T_ONE;
            end
         end
         S_OVER, S_WIN: begin
            if (start_e) state_d = S_IDLE;
         end
`ifdef PAUSE_EN
         S_PAUSED: begin
            if (pause_e) state_d = S_PLAY;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      score_start_d = (state_q == S_IDLE) && (state_d == S_SERVE);
      ball_launch_d = (state_q == S_SERVE) && (state_d == S_PLAY);
      ball_hold_d   = (state_d == S_SERVE);
      play_en_d     = (state_d == S_PLAY);
      game_over_d   = (state_d == S_OVER);
      victory_d     = (state_d == S_WIN);
   end

   assign bus_io.state       = state_q;
   assign bus_io.score_start = score_start_q;
   assign bus_io.ball_launch = ball_launch_q;
   assign bus_io.ball_hold   = ball_hold_q;
   assign bus_io.play_en     = play_en_q;
   assign bus_io.lives_left  = lives_q;
   assign bus_io.blocks_left = blocks_q;
   assign bus_io.game_over   = game_over_q;
   assign bus_io.victory     = victory_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with NUM_BLOCKS=3, LIVES=2, SERVE_DELAY=4, LOST_DELAY=3.
// Define PAUSE_EN for both files to exercise the pause state.
module tb_game_sequencer;
   localparam int NB = 3;
   localparam int NL = 2;
   localparam int SD = 4;
   localparam int LD = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;

   game_sequencer_if #(.NUM_BLOCKS(NB)) bus ();

   game_sequencer #(
      .NUM_BLOCKS (NB),
      .LIVES      (NL),
      .SERVE_DELAY(SD),
      .LOST_DELAY (LD)
   ) dut (
      .clock_i(clk),
      .reset_i(rst_n),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.hit_block = 1'b0;
      bus.hit_lava = 1'b0;
      bus.endgame_block = 1'b0;
`ifdef PAUSE_EN
      bus.pause = 1'b0;
`endif
      // reset state
      tick(2);
      rst_n = 1'b1;
      tick();
      chk("rst_state", bus.state, 0);
      chk("rst_lives", bus.lives_left, 2);
      chk("rst_blocks", bus.blocks_left, 3);
      chk("rst_score", bus.score_start, 0);
      chk("rst_launch", bus.ball_launch, 0);
      chk("rst_play", bus.play_en, 0);
      chk("rst_hold", bus.ball_hold, 0);
      chk("rst_over", bus.game_over, 0);
      chk("rst_win", bus.victory, 0);

      // start, serve, auto-launch
      bus.start = 1'b1;
      tick();
      chk("srv_state", bus.state, 1);
      chk("srv_score", bus.score_start, 1);
      chk("srv_hold", bus.ball_hold, 1);
      bus.start = 1'b0;
      tick();
      chk("srv_score_end", bus.score_start, 0);
      tick(2);
      chk("srv_wait_state", bus.state, 1);
      chk("srv_wait_launch", bus.ball_launch, 0);
      tick();
      chk("launch_state", bus.state, 2);
      chk("launch_pulse", bus.ball_launch, 1);
      chk("launch_play", bus.play_en, 1);
      chk("launch_hold", bus.ball_hold, 0);
      tick();
      chk("launch_end", bus.ball_launch, 0);

      // held hit_block counts once, then clear wall
      bus.hit_block = 1'b1;
      tick();
      chk("blk_first", bus.blocks_left, 2);
      tick(4);
      chk("blk_held", bus.blocks_left, 2);
      chk("blk_held_state", bus.state, 2);
      bus.hit_block = 1'b0;
      tick();
      bus.hit_block = 1'b1;
      tick();
      chk("blk_second", bus.blocks_left, 1);
      bus.hit_block = 1'b0;
      tick();
      bus.hit_block = 1'b1;
      tick();
      chk("blk_zero", bus.blocks_left, 0);
      chk("win_state", bus.state, 5);
      chk("win_flag", bus.victory, 1);
      chk("win_play", bus.play_en, 0);
      bus.hit_block = 1'b0;
      bus.hit_lava = 1'b1;
      tick();
      chk("win_lava_ign", bus.lives_left, 2);
      chk("win_hold", bus.state, 5);
      bus.hit_lava = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      chk("win_to_idle", bus.state, 0);
      chk("win_flag_clr", bus.victory, 0);
      bus.start = 1'b0;
      tick();

      // new game, early launch by start, lose both lives
      bus.start = 1'b1;
      tick();
      chk("g2_state", bus.state, 1);
      chk("g2_blocks", bus.blocks_left, 3);
      chk("g2_lives", bus.lives_left, 2);
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      chk("early_launch_state", bus.state, 2);
      chk("early_launch_pulse", bus.ball_launch, 1);
      bus.start = 1'b0;
      bus.hit_lava = 1'b1;
      tick();
      chk("lost_lives", bus.lives_left, 1);
      chk("lost_state0", bus.state, 3);
      chk("lost_play", bus.play_en, 0);
      bus.hit_lava = 1'b0;
      tick();
      chk("lost_state1", bus.state, 3);
      tick();
      chk("lost_state2", bus.state, 3);
      tick();
      chk("lost_to_serve", bus.state, 1);
      chk("lost_hold", bus.ball_hold, 1);
      tick(4);
      chk("reserve_play", bus.state, 2);
      bus.hit_lava = 1'b1;
      tick();
      chk("over_lives", bus.lives_left, 0);
      chk("over_state", bus.state, 4);
      chk("over_flag", bus.game_over, 1);
      bus.hit_lava = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      chk("over_to_idle", bus.state, 0);
      chk("over_flag_clr", bus.game_over, 0);
      bus.start = 1'b0;
      tick();

      // simultaneous events: endgame wins, others dropped
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      chk("g3_play", bus.state, 2);
      bus.start = 1'b0;
      tick();
      bus.hit_lava = 1'b1;
      bus.hit_block = 1'b1;
      bus.endgame_block = 1'b1;
      tick();
      chk("prio_state", bus.state, 4);
      chk("prio_lives", bus.lives_left, 2);
      chk("prio_blocks", bus.blocks_left, 3);
      chk("prio_over", bus.game_over, 1);
      bus.hit_lava = 1'b0;
      bus.hit_block = 1'b0;
      bus.endgame_block = 1'b0;
      tick();

      // mid-game reset during serve
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1;
      tick();
      chk("g4_play", bus.state, 2);
      bus.start = 1'b0;
      bus.hit_block = 1'b1;
      tick();
      chk("g4_blocks", bus.blocks_left, 2);
      bus.hit_block = 1'b0;
      tick();
`ifdef PAUSE_EN
      bus.pause = 1'b1;
      tick();
      chk("pause_state", bus.state, 6);
      chk("pause_play", bus.play_en, 0);
      bus.pause = 1'b0;
      bus.hit_lava = 1'b1;
      tick();
      chk("pause_lava_ign", bus.lives_left, 2);
      chk("pause_hold", bus.state, 6);
      bus.hit_lava = 1'b0;
      tick();
      bus.pause = 1'b1;
      tick();
      chk("resume_state", bus.state, 2);
      chk("resume_play", bus.play_en, 1);
      chk("resume_launch", bus.ball_launch, 0);
      bus.pause = 1'b0;
      tick();
`endif
      bus.hit_lava = 1'b1;
      tick();
      chk("g4_lost", bus.state, 3);
      bus.hit_lava = 1'b0;
      tick(3);
      chk("g4_serve", bus.state, 1);
      rst_n = 1'b0;
      tick();
      chk("mrst_state", bus.state, 0);
      chk("mrst_blocks", bus.blocks_left, 3);
      chk("mrst_lives", bus.lives_left, 2);
      chk("mrst_hold", bus.ball_hold, 0);
      chk("mrst_score", bus.score_start, 0);
      rst_n = 1'b1;
      tick();
      chk("mrst_idle", bus.state, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
